// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith ops; MUL runs a WIDTH-step shift-add sequence.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     mplier;
    logic                 accept;
    logic                 is_mul;
    logic                 retire;
    logic                 mul_done;
    logic [WIDTH:0]       ext;
    logic [WIDTH-1:0]     alu_sum;
    logic                 alu_c;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (oper == OP_MUL);
    assign retire   = out_valid && out_ready;
    assign mul_done = (state == MUL) && (cnt == CW'(1));

    // One multiplier bit per edge, LSB first; mcand is pre-shifted each step.
    assign acc_step = acc + (mplier[0] ? mcand : {2*WIDTH{1'b0}});

    always_comb begin
        ext     = '0;
        alu_sum = '0;
        alu_c   = 1'b0;
        unique case (oper)
            OP_ADD: begin
                ext     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
                alu_sum = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow.
                ext     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_in};
                alu_sum = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_AND: alu_sum = a & b;
            OP_OR:  alu_sum = a | b;
            OP_XOR: alu_sum = a ^ b;
            OP_SHL: begin
                alu_sum = {a[WIDTH-2:0], c_in};
                alu_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_sum = {c_in, a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            default: begin
                alu_sum = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept && is_mul) state_next = MUL;
            MUL:  if (cnt == CW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            sum       <= alu_sum;
            c_out     <= alu_c;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            sum       <= acc_step[WIDTH-1:0];
            c_out     <= |acc_step[2*WIDTH-1:WIDTH];
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (accept && is_mul) begin
            cnt    <= CW'(WIDTH);
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (state == MUL) begin
            cnt    <= cnt - CW'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_step;
        end
    end

endmodule
